// File: rtl/shift_rows_col_feeder.sv
// shift_rows_col_feeder: registered AES ShiftRows that streams the shifted state one column per handshake
module shift_rows_col_feeder (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_skip_mix,
  output logic         col_valid,
  input  logic         col_ready,
  output logic [31:0]  col_data,
  output logic [1:0]   col_idx,
  output logic         col_last,
  output logic         col_skip_mix
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state, state_d;
  logic [1:0] cnt;
  logic [0:3][31:0] sr_q, shifted;
  logic skip_q, load, last_acc;
  genvar r, c;
  generate
    for (c = 0; c < 4; c++) begin : g_col
      for (r = 0; r < 4; r++) begin : g_row
        assign shifted[c][31-8*r -: 8] = in_state[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  endgenerate
  always_comb begin
    last_acc = (state == SEND) & (cnt == 2'd3) & col_ready;
    in_ready = (state == IDLE) | last_acc;
    load = in_valid & in_ready;
    state_d = load ? SEND : last_acc ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 2'd0;
      sr_q   <= '0;
      skip_q <= 1'b0;
    end else begin
      state <= state_d;
      if (load) begin
        sr_q   <= shifted;
        skip_q <= in_skip_mix;
        cnt    <= 2'd0;
      end else if (state == SEND && col_ready) cnt <= cnt + 2'd1;
    end
  end
  assign col_valid    = (state == SEND);
  assign col_data     = sr_q[cnt];
  assign col_idx      = cnt;
  assign col_last     = (cnt == 2'd3);
  assign col_skip_mix = skip_q;
endmodule

// File: tb/tb_shift_rows_col_feeder.sv
// tb_shift_rows_col_feeder: directed table-driven checks of the ShiftRows column feeder
module tb_shift_rows_col_feeder;
  logic clk = 1'b0, rst, in_valid, in_ready, in_skip_mix;
  logic col_valid, col_ready, col_last, col_skip_mix;
  logic [127:0] in_state;
  logic [31:0] col_data;
  logic [1:0] col_idx;
  int checks = 0, errors = 0;
  typedef struct {
    logic [127:0] st;
    logic [0:3][31:0] col;
  } vec_t;
  vec_t tv [3];
  shift_rows_col_feeder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_skip_mix(in_skip_mix), .col_valid(col_valid),
    .col_ready(col_ready), .col_data(col_data), .col_idx(col_idx),
    .col_last(col_last), .col_skip_mix(col_skip_mix)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic run_block(input int v, input logic sk);
    in_valid = 1'b1;
    in_state = tv[v].st;
    in_skip_mix = sk;
    col_ready = 1'b1;
    chk("in_ready_idle", 128'(in_ready), 128'(1'b1));
    step;
    in_valid = 1'b0;
    in_state = '0;
    in_skip_mix = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("col_valid", 128'(col_valid), 128'(1'b1));
      chk("col_data", 128'(col_data), 128'(tv[v].col[i]));
      chk("col_idx", 128'(col_idx), 128'(i));
      chk("col_last", 128'(col_last), 128'(i == 3));
      chk("col_skip_mix", 128'(col_skip_mix), 128'(sk));
      step;
    end
    chk("idle_after_block", 128'(col_valid), 128'(1'b0));
  endtask
  initial begin
    int nacc, cyc;
    tv[0].st = 128'hd42711aee0bf98f1b8b45de51e415230;
    tv[0].col = {32'hd4bf5d30, 32'he0b452ae, 32'hb84111f1, 32'h1e2798e5};
    tv[1].st = 128'h000102030405060708090a0b0c0d0e0f;
    tv[1].col = {32'h00050a0f, 32'h04090e03, 32'h080d0207, 32'h0c01060b};
    tv[2].st = 128'h00112233445566778899aabbccddeeff;
    tv[2].col = {32'h0055aaff, 32'h4499ee33, 32'h88dd2277, 32'hcc1166bb};
    rst = 1'b1; in_valid = 1'b1; in_state = tv[0].st; in_skip_mix = 1'b1; col_ready = 1'b1;
    step;
    step;
    rst = 1'b0; in_valid = 1'b0; in_skip_mix = 1'b0;
    chk("rst_col_valid", 128'(col_valid), 128'(1'b0));
    chk("rst_col_data", 128'(col_data), 128'(32'h0));
    chk("rst_col_idx", 128'(col_idx), 128'(2'd0));
    chk("rst_col_last", 128'(col_last), 128'(1'b0));
    chk("rst_col_skip", 128'(col_skip_mix), 128'(1'b0));
    chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
    for (int v = 0; v < 3; v++) run_block(v, v[0]);
    // back-to-back: second block loads as the first block's column 3 is accepted
    in_valid = 1'b1; in_state = tv[0].st; in_skip_mix = 1'b0; col_ready = 1'b1;
    step;
    in_state = tv[1].st; in_skip_mix = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("b2b_valid", 128'(col_valid), 128'(1'b1));
      chk("b2b_data", 128'(col_data), 128'(tv[i / 4].col[i % 4]));
      chk("b2b_idx", 128'(col_idx), 128'(i % 4));
      chk("b2b_skip", 128'(col_skip_mix), 128'(i >= 4));
      chk("b2b_in_ready", 128'(in_ready), 128'(i % 4 == 3));
      step;
      if (i == 3) begin
        in_valid = 1'b0; in_state = '0; in_skip_mix = 1'b0;
      end
    end
    chk("b2b_idle", 128'(col_valid), 128'(1'b0));
    // backpressure: stall three cycles while column 1 is presented
    in_valid = 1'b1; in_state = tv[2].st;
    step;
    in_valid = 1'b0;
    nacc = 0;
    for (cyc = 0; cyc < 20; cyc++) begin
      col_ready = !(cyc >= 1 && cyc <= 3);
      chk("bp_valid", 128'(col_valid), 128'(1'b1));
      chk("bp_idx", 128'(col_idx), 128'(nacc));
      chk("bp_data", 128'(col_data), 128'(tv[2].col[nacc]));
      if (col_ready) nacc++;
      step;
      if (nacc == 4) break;
    end
    chk("bp_cols_accepted", 128'(nacc), 128'(4));
    chk("bp_cycles", 128'(cyc + 1), 128'(7));
    col_ready = 1'b1;
    // in_valid during a block is ignored, then reset after column 1 discards the block
    in_valid = 1'b1; in_state = tv[0].st; in_skip_mix = 1'b1;
    step;
    in_state = tv[1].st; in_skip_mix = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("mid_in_ready", 128'(in_ready), 128'(1'b0));
      chk("mid_data", 128'(col_data), 128'(tv[0].col[i]));
      chk("mid_skip", 128'(col_skip_mix), 128'(1'b1));
      step;
    end
    in_valid = 1'b0; rst = 1'b1;
    step;
    rst = 1'b0;
    chk("mrst_col_valid", 128'(col_valid), 128'(1'b0));
    chk("mrst_col_data", 128'(col_data), 128'(32'h0));
    chk("mrst_col_idx", 128'(col_idx), 128'(2'd0));
    chk("mrst_col_last", 128'(col_last), 128'(1'b0));
    chk("mrst_col_skip", 128'(col_skip_mix), 128'(1'b0));
    chk("mrst_in_ready", 128'(in_ready), 128'(1'b1));
    run_block(1, 1'b0);
    // idle gap then a fresh block
    for (int i = 0; i < 3; i++) begin
      step;
      chk("gap_valid", 128'(col_valid), 128'(1'b0));
      chk("gap_in_ready", 128'(in_ready), 128'(1'b1));
    end
    run_block(2, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/shift_rows_col_feeder.md
# shift_rows_col_feeder

Registered ShiftRows stage that accepts one 128-bit AES state per handshake after SubBytes. It applies ShiftRows and delivers the result one 32-bit column per cycle to the column-wide MixColumns calculator that follows it. A per-block `skip_mix` flag travels with each column, so the downstream stage bypasses MixColumns in the final round. The stage is fully pipelined: a new block loads in the same cycle the last column of the previous block is accepted.

## Interface

Parameters: none.

- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  upstream block valid
- `in_ready`  out  1  stage can accept a block this cycle
- `in_state`  in  128  SubBytes output, column-major: byte (row r, col c) at bits [127-8(4c+r) -: 8]
- `in_skip_mix`  in  1  final-round flag for this block
- `col_valid`  out  1  `col_data` valid
- `col_ready`  in  1  downstream accepts the column
- `col_data`  out  32  shifted column: row0 in [31:24], row3 in [7:0]
- `col_idx`  out  2  column number 0..3
- `col_last`  out  1  high when `col_idx`==3
- `col_skip_mix`  out  1  registered copy of `in_skip_mix` for the current block

## Operation

- ShiftRows mapping: output (r,c) = input (r, (c+r) mod 4).
  - Row 0 is unshifted; rows 1/2/3 rotate left by 1/2/3 bytes.
  - The mapping is fixed wiring, applied at load time into a 128-bit holding register `sr_q`.
- State machine:
  - IDLE: `in_ready`=1, `col_valid`=0.
    - `in_valid` high: load `sr_q`, latch skip flag, clear `cnt`, go to SEND.
  - SEND: `col_valid`=1, `col_data` = column `cnt` of `sr_q`.
    - `col_ready` high and `cnt`<3: increment `cnt`.
    - `col_ready` high and `cnt`==3, `in_valid` high: reload `sr_q`/flag, set `cnt`=0, stay in SEND.
    - `col_ready` high and `cnt`==3, `in_valid` low: go to IDLE, `cnt`=0.
    - `col_ready` low: hold all outputs stable.
- `in_ready` = (state==IDLE) | (state==SEND & `cnt`==3 & `col_ready`). This is the only combinational input-to-output path.
- `cnt` is 2 bits. It never wraps without a block transfer; 3→0 occurs only on acceptance of the last column.
- Reset mid-block: the block is discarded. The next cycle is IDLE, and no partial column is re-emitted.
- `in_valid` while SEND and not at the last accepted column: ignored; `in_ready` is low.
- Reset values: state=IDLE, `cnt`=0, `sr_q`=0, skip flag=0, `col_valid`=0, `col_data`=0, `col_idx`=0, `col_last`=0, `col_skip_mix`=0, `in_ready`=1 (from IDLE once `rst` deasserts; 0 is not required during reset).

## Timing

- Latency: input handshake at edge T gives column 0 valid in cycle T+1.
- With `col_ready` held high, columns 0..3 appear in cycles T+1..T+4.
- Throughput: one block per 4 cycles with back-to-back input; no bubble between blocks.
- `col_data`, `col_idx`, `col_last`, `col_skip_mix` derive only from registers, with no combinational dependence on `in_*`.
- Stall: outputs hold their value for any number of `col_ready`=0 cycles.
- Simultaneous `rst` and handshake: `rst` wins and nothing is loaded.

## Test plan

- **Single block (FIPS-197 round 1).**
  - Stimulus: `in_state`=d42711aee0bf98f1b8b45de51e415230, `col_ready`=1.
  - Required: columns d4bf5d30, e0b452ae, b84111f1, 1e2798e5 at `col_idx` 0..3 on consecutive cycles.
  - Required: `col_last` high only on column 3; `col_skip_mix`=0.
- **Byte-index check.**
  - Stimulus: `in_state`=000102030405060708090a0b0c0d0e0f.
  - Required: columns 00050a0f, 04090e03, 080d0207, 0c01060b.
- **Back-to-back.**
  - Stimulus: two blocks with `in_valid` continuously high, second block with `in_skip_mix`=1.
  - Required: 8 consecutive valid columns with no gap; `in_ready` pulses high exactly in the cycle column 3 is accepted; `col_skip_mix` flips to 1 at the second block's column 0.
- **Backpressure.**
  - Stimulus: `col_ready` low for 3 cycles during column 1.
  - Required: `col_data`/`col_idx` stable throughout; no column skipped or duplicated; total 7 cycles from column 0 to column 3 accepted.
- **Reset mid-block.**
  - Stimulus: assert `rst` after column 1 is accepted.
  - Required: next cycle `col_valid`=0 and all outputs at their reset values; a fresh block then starts at `col_idx`=0.
- **Idle gap.**
  - Stimulus: `in_valid` low after a block.
  - Required: return to IDLE with `col_valid`=0 and `in_ready`=1; the next block's column 0 appears one cycle after its handshake.
